// File: rtl/fft_r2_engine.sv
`default_nettype none
// ============================================================================
// Module : fft_r2_engine
// Brief  : Iterative in-place radix-2 DIT FFT/IFFT with one time-shared butterfly.
// Rev    : 1.0
// ============================================================================
module fft_r2_engine #(
    parameter int N_LOG2 = 3,
    parameter int DW     = 17,
    parameter int TW     = 18,
    parameter int SCALE  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 inverse,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_re,
    output logic signed [DW-1:0] out_im,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);
    localparam int N     = 1 << N_LOG2;
    localparam int SGW   = $clog2(N_LOG2 + 1);
    localparam int C_TIW = N_LOG2 - 1;
    localparam int PW    = DW + TW + 1;
    localparam int EW    = DW + 3;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_CALC   = 2'd2;
    localparam logic [1:0] S_UNLOAD = 2'd3;

    localparam logic [N_LOG2-1:0]  C_LAST       = N_LOG2'(N - 1);
    localparam logic [N_LOG2-1:0]  C_HALF_LAST  = N_LOG2'(N / 2 - 1);
    localparam logic [SGW-1:0]     C_STAGE_LAST = SGW'(N_LOG2 - 1);
    localparam logic signed [EW-1:0] C_MAX      = EW'((64'sd1 <<< (DW - 1)) - 64'sd1);
    localparam logic signed [EW-1:0] C_MIN      = ~C_MAX;
    localparam logic signed [PW-1:0] C_RND      = PW'(64'sd1 <<< (TW - 3));

    logic [1:0]           state_q, state_d;
    logic [N_LOG2-1:0]    cnt_q, cnt_d;
    logic [SGW-1:0]       stage_q, stage_d;
    logic                 inv_q, inv_d;
    logic                 done_q, done_d;
    logic signed [DW-1:0] ram_re_q [N];
    logic signed [DW-1:0] ram_im_q [N];
    logic signed [DW-1:0] ram_re_d [N];
    logic signed [DW-1:0] ram_im_d [N];
    logic signed [TW-1:0] rom_cos  [N/2];
    logic signed [TW-1:0] rom_sin  [N/2];

    function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] x);
        logic [N_LOG2-1:0] r;
        for (int i = 0; i < N_LOG2; i++) r[i] = x[N_LOG2-1-i];
        return r;
    endfunction

    // Optional halving (round half-up) followed by saturation to DW bits.
    function automatic logic signed [DW-1:0] finish_sum(input logic signed [EW-1:0] x);
        logic signed [EW-1:0] v;
        v = x;
        if (SCALE != 0) v = (x + EW'(1)) >>> 1;
        if (v > C_MAX) return DW'(C_MAX);
        if (v < C_MIN) return DW'(C_MIN);
        return DW'(v);
    endfunction

    for (genvar gi = 0; gi < N / 2; gi++) begin : g_twiddle
        localparam real C_ANG = 6.283185307179586 * gi / N;
        localparam real C_ONE = real'(64'sd1 <<< (TW - 2));
        localparam int  C_COS = $rtoi($floor($cos(C_ANG) * C_ONE + 0.5));
        localparam int  C_SIN = $rtoi($floor($sin(C_ANG) * C_ONE + 0.5));
        assign rom_cos[gi] = TW'(C_COS);
        assign rom_sin[gi] = TW'(C_SIN);
    end

    // Butterfly addressing: insert a zero bit at position 'stage' into the butterfly index.
    logic [N_LOG2-1:0]    w_mask, w_j, w_a_idx, w_b_idx;
    logic [SGW-1:0]       w_tw_shift;
    logic [C_TIW-1:0]     w_tw_idx;
    logic signed [TW-1:0] w_wr, w_wi;
    logic signed [DW-1:0] w_ar, w_ai, w_br, w_bi;
    logic signed [PW-1:0] w_tr_full, w_ti_full;
    logic signed [EW-1:0] w_tr, w_ti;
    logic signed [DW-1:0] w_a_re, w_a_im, w_b_re, w_b_im;

    always_comb begin
        w_mask     = (N_LOG2'(1) << stage_q) - N_LOG2'(1);
        w_j        = cnt_q & w_mask;
        w_a_idx    = ((cnt_q & ~w_mask) << 1) | w_j;
        w_b_idx    = w_a_idx | (N_LOG2'(1) << stage_q);
        w_tw_shift = SGW'(N_LOG2 - 1) - stage_q;
        w_tw_idx   = C_TIW'(w_j << w_tw_shift);
        w_wr       = rom_cos[w_tw_idx];
        w_wi       = inv_q ? rom_sin[w_tw_idx] : -rom_sin[w_tw_idx];
        w_ar       = ram_re_q[w_a_idx];
        w_ai       = ram_im_q[w_a_idx];
        w_br       = ram_re_q[w_b_idx];
        w_bi       = ram_im_q[w_b_idx];
        w_tr_full  = PW'(w_br) * PW'(w_wr) - PW'(w_bi) * PW'(w_wi) + C_RND;
        w_ti_full  = PW'(w_br) * PW'(w_wi) + PW'(w_bi) * PW'(w_wr) + C_RND;
        w_tr       = EW'(w_tr_full >>> (TW - 2));
        w_ti       = EW'(w_ti_full >>> (TW - 2));
        w_a_re     = finish_sum(EW'(w_ar) + w_tr);
        w_a_im     = finish_sum(EW'(w_ai) + w_ti);
        w_b_re     = finish_sum(EW'(w_ar) - w_tr);
        w_b_im     = finish_sum(EW'(w_ai) - w_ti);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            stage_q <= '0;
            inv_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            inv_q   <= inv_d;
            done_q  <= done_d;
        end
    end

    // Start is blocked during the done cycle so back-to-back starts need one IDLE cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        inv_d   = inv_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !done_q) begin
                    state_d = S_LOAD;
                    inv_d   = inverse;
                    cnt_d   = '0;
                    stage_d = '0;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == C_LAST) begin
                        state_d = S_CALC;
                        cnt_d   = '0;
                        stage_d = '0;
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_HALF_LAST) begin
                    cnt_d   = '0;
                    stage_d = stage_q + 1'b1;
                    if (stage_q == C_STAGE_LAST) begin
                        state_d = S_UNLOAD;
                        stage_d = '0;
                    end
                end
            end
            S_UNLOAD: begin
                if (out_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == C_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ram_re_d = ram_re_q;
        ram_im_d = ram_im_q;
        if (state_q == S_LOAD && in_valid) begin
            ram_re_d[bitrev(cnt_q)] = in_re;
            ram_im_d[bitrev(cnt_q)] = in_im;
        end else if (state_q == S_CALC) begin
            ram_re_d[w_a_idx] = w_a_re;
            ram_im_d[w_a_idx] = w_a_im;
            ram_re_d[w_b_idx] = w_b_re;
            ram_im_d[w_b_idx] = w_b_im;
        end
    end

    // Sample storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        ram_re_q <= ram_re_d;
        ram_im_q <= ram_im_d;
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_re    = '0;
        out_im    = '0;
        busy      = (state_q != S_IDLE);
        done      = done_q;
        case (state_q)
            S_LOAD: in_ready = 1'b1;
            S_UNLOAD: begin
                out_valid = 1'b1;
                out_last  = (cnt_q == C_LAST);
                out_re    = ram_re_q[cnt_q];
                out_im    = ram_im_q[cnt_q];
            end
            default: ;
        endcase
    end
endmodule
`default_nettype wire
